// File: rtl/nrs_symbol_scheduler.sv
// ---------------------------------------------------------------------------
// nrs_symbol_scheduler
//
// Sequences the NRS Gold-sequence generator across one radio frame. For every
// NRS-bearing symbol (l = 5 and 6 of each slot, subframe 5 excluded) it
// computes c_init, loads the generator seed, runs the warm-up plus output
// shifts and then presents NRS_gen_ready until the channel estimator
// acknowledges the symbol.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   new_frame       frame strobe: restarts the schedule, latches N_cell_ID
//   new_subframe    subframe strobe (advances the schedule between subframes)
//   N_cell_ID       cell identity, sampled only with new_frame
//   est_ack         estimator has consumed the current symbol
//   cinit           registered x2 seed for the Gold generator
//   seed_load       generator loads x1 = 1, x2 = cinit
//   shift_en        generator advances one step
//   ns, l           current slot / symbol index (stable while ready)
//   NRS_gen_ready   generator output valid for the estimator
//   frame_done      one-cycle pulse after the final symbol of the frame
//   sf_overrun      one-cycle pulse when a subframe strobe is lost
// ---------------------------------------------------------------------------
module nrs_symbol_scheduler #(
    parameter int WIDTH_B    = 9,
    parameter int NUM_SHIFTS = 1570,
    parameter int OUT_SHIFTS = 4,
    parameter int CINIT_W    = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_frame,
    input  logic               new_subframe,
    input  logic [WIDTH_B-1:0] N_cell_ID,
    input  logic               est_ack,
    output logic [CINIT_W-1:0] cinit,
    output logic               seed_load,
    output logic               shift_en,
    output logic [4:0]         ns,
    output logic [2:0]         l,
    output logic               NRS_gen_ready,
    output logic               frame_done,
    output logic               sf_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_SEED    = 3'd2,
        ST_WARM    = 3'd3,
        ST_READY   = 3'd4,
        ST_NEXT    = 3'd5,
        ST_WAIT_SF = 3'd6
    } state_t;

    // WARM runs from this value down to zero inclusive.
    localparam logic [10:0] WARM_LAST = 11'(NUM_SHIFTS + OUT_SHIFTS - 1);

    state_t               state_q, state_d;
    logic [4:0]           ns_q, ns_d;
    logic [2:0]           l_q, l_d;
    logic [3:0]           sf_q, sf_d;
    logic                 pending_q, pending_d;
    logic [WIDTH_B-1:0]   cell_id_q, cell_id_d;
    logic [CINIT_W-1:0]   cinit_q, cinit_d;
    logic [10:0]          cnt_q, cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 sf_overrun_q, sf_overrun_d;

    logic                 sf_event_s;
    logic [3:0]           sf_inc_s;
    logic [7:0]           sym_term_s;
    logic [WIDTH_B:0]     cell_term_s;
    logic [CINIT_W-1:0]   cinit_calc_s;

    // c_init = (7*(ns+1)+l+1)*(2*N_cell_ID+1)*2^10 + 2*N_cell_ID+1
    always_comb begin
        sym_term_s   = 8'd7 * (8'(ns_q) + 8'd1) + 8'(l_q) + 8'd1;
        cell_term_s  = {cell_id_q, 1'b0} + {{WIDTH_B{1'b0}}, 1'b1};
        cinit_calc_s = ((CINIT_W'(sym_term_s) * CINIT_W'(cell_term_s)) << 10)
                       + CINIT_W'(cell_term_s);
    end

    // A subframe boundary is either a live strobe or one remembered earlier.
    always_comb begin
        sf_event_s = new_subframe | pending_q;
        sf_inc_s   = sf_q + 4'd1;
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ns_q         <= 5'd0;
            l_q          <= 3'd5;
            sf_q         <= 4'd0;
            pending_q    <= 1'b0;
            cell_id_q    <= {WIDTH_B{1'b0}};
            cinit_q      <= {CINIT_W{1'b0}};
            cnt_q        <= 11'd0;
            frame_done_q <= 1'b0;
            sf_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ns_q         <= ns_d;
            l_q          <= l_d;
            sf_q         <= sf_d;
            pending_q    <= pending_d;
            cell_id_q    <= cell_id_d;
            cinit_q      <= cinit_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            sf_overrun_q <= sf_overrun_d;
        end
    end

    // Next-state logic; new_frame overrides every state.
    always_comb begin
        state_d = state_q;
        if (new_frame) begin
            state_d = ST_CALC;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_CALC:  state_d = ST_SEED;
                ST_SEED:  state_d = ST_WARM;
                ST_WARM: begin
                    if (cnt_q == 11'd0) state_d = ST_READY;
                    else                state_d = ST_WARM;
                end
                ST_READY: begin
                    if (est_ack) state_d = ST_NEXT;
                    else         state_d = ST_READY;
                end
                ST_NEXT: begin
                    if (l_q == 3'd5)       state_d = ST_CALC;
                    else if (!ns_q[0])     state_d = ST_CALC;
                    else if (sf_q == 4'd9) state_d = ST_IDLE;
                    else                   state_d = ST_WAIT_SF;
                end
                ST_WAIT_SF: begin
                    // Subframe 5 carries no NRS: keep waiting for subframe 6.
                    if (sf_event_s && (sf_inc_s != 4'd5)) state_d = ST_CALC;
                    else                                  state_d = ST_WAIT_SF;
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: symbol position, subframe tracking, seed, counter.
    always_comb begin
        ns_d         = ns_q;
        l_d          = l_q;
        sf_d         = sf_q;
        pending_d    = pending_q;
        cell_id_d    = cell_id_q;
        cinit_d      = cinit_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        sf_overrun_d = 1'b0;
        if (new_frame) begin
            cell_id_d = N_cell_ID;
            ns_d      = 5'd0;
            l_d       = 3'd5;
            sf_d      = 4'd0;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_CALC: cinit_d = cinit_calc_s;
                ST_SEED: cnt_d   = WARM_LAST;
                ST_WARM: begin
                    if (cnt_q != 11'd0) cnt_d = cnt_q - 11'd1;
                    else                cnt_d = cnt_q;
                end
                ST_NEXT: begin
                    if (l_q == 3'd5) begin
                        l_d = 3'd6;
                    end else if (!ns_q[0]) begin
                        ns_d = ns_q + 5'd1;
                        l_d  = 3'd5;
                    end else if (sf_q == 4'd9) begin
                        frame_done_d = 1'b1;
                    end else begin
                        frame_done_d = 1'b0;
                    end
                end
                ST_WAIT_SF: begin
                    if (sf_event_s) begin
                        sf_d      = sf_inc_s;
                        // A live strobe coinciding with a pending one stays queued.
                        pending_d = pending_q & new_subframe;
                        if (sf_inc_s != 4'd5) begin
                            ns_d = {sf_inc_s, 1'b0};
                            l_d  = 3'd5;
                        end else begin
                            ns_d = ns_q;
                        end
                    end else begin
                        sf_d = sf_q;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
            // Strobes seen while busy are remembered; a second one is lost.
            if (new_subframe && (state_q != ST_IDLE) && (state_q != ST_WAIT_SF)) begin
                pending_d    = 1'b1;
                sf_overrun_d = pending_q;
            end else begin
                sf_overrun_d = 1'b0;
            end
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        seed_load     = 1'b0;
        shift_en      = 1'b0;
        NRS_gen_ready = 1'b0;
        case (state_q)
            ST_SEED:  seed_load     = 1'b1;
            ST_WARM:  shift_en      = 1'b1;
            ST_READY: NRS_gen_ready = 1'b1;
            default:  seed_load     = 1'b0;
        endcase
    end

    assign cinit      = cinit_q;
    assign ns         = ns_q;
    assign l          = l_q;
    assign frame_done = frame_done_q;
    assign sf_overrun = sf_overrun_q;

endmodule

// File: tb/tb_nrs_symbol_scheduler.sv
// Scoreboard bench for nrs_symbol_scheduler. The frame plan (ordered list of
// NRS symbols and their c_init) is derived from the frame structure with plain
// loops and arithmetic; a monitor pops one entry per NRS_gen_ready rise.
module tb_nrs_symbol_scheduler;

    logic        clk = 1'b0;
    logic        rst, new_frame, new_subframe, est_ack;
    logic [8:0]  N_cell_ID;
    logic [27:0] cinit;
    logic        seed_load, shift_en, NRS_gen_ready, frame_done, sf_overrun;
    logic [4:0]  ns;
    logic [2:0]  l;

    nrs_symbol_scheduler dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .new_subframe(new_subframe),
        .N_cell_ID(N_cell_ID), .est_ack(est_ack), .cinit(cinit),
        .seed_load(seed_load), .shift_en(shift_en), .ns(ns), .l(l),
        .NRS_gen_ready(NRS_gen_ready), .frame_done(frame_done),
        .sf_overrun(sf_overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int ns; int l; int cinit; } sym_t;
    sym_t exp_q[$];
    int   plan_sf[$];
    int   errors = 0;
    int   checks = 0;
    int   fd_cnt = 0;
    int   ov_cnt = 0;
    int   exp_fd = 0;
    int   exp_ov = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int model_cinit(input int n_s, input int sym_l, input int id);
        return (7 * (n_s + 1) + sym_l + 1) * (2 * id + 1) * 1024 + 2 * id + 1;
    endfunction

    // Expected symbol order for a whole frame.
    task automatic plan_frame(input int id);
        sym_t e;
        exp_q.delete();
        plan_sf.delete();
        for (int sf = 0; sf < 10; sf++) begin
            if (sf != 5) begin
                for (int s = 0; s < 2; s++) begin
                    for (int ll = 5; ll <= 6; ll++) begin
                        e.ns = 2 * sf + s;
                        e.l = ll;
                        e.cinit = model_cinit(e.ns, ll, id);
                        exp_q.push_back(e);
                        plan_sf.push_back(sf);
                    end
                end
            end
        end
    endtask

    // Monitor: pop on every ready rise, verify tags stay put while ready.
    sym_t cur;
    int   shift_cnt = 0;
    logic prev_ready = 1'b0;
    logic prev_seed = 1'b0;
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (sf_overrun) ov_cnt++;
        if (seed_load) begin
            check("seed_pulse_width", int'(prev_seed), 0);
            shift_cnt = 0;
        end
        if (shift_en) shift_cnt++;
        if (NRS_gen_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: ns=%0d l=%0d with no symbol expected", ns, l);
            end else begin
                cur = exp_q.pop_front();
                check("sym_ns", int'(ns), cur.ns);
                check("sym_l", int'(l), cur.l);
                check("sym_cinit", int'(cinit), cur.cinit);
                check("warm_shifts", shift_cnt, 1574);
            end
        end else if (NRS_gen_ready && prev_ready) begin
            check("hold_ns", int'(ns), cur.ns);
            check("hold_l", int'(l), cur.l);
            check("hold_cinit", int'(cinit), cur.cinit);
        end
        prev_ready = NRS_gen_ready;
        prev_seed  = seed_load;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!NRS_gen_ready && cyc < 4000) begin
            tick();
            cyc++;
        end
        if (!NRS_gen_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: waited %0d cycles", cyc);
        end
    endtask

    task automatic ack(input int hold);
        repeat (hold) tick();
        est_ack = 1'b1;
        tick();
        est_ack = 1'b0;
    endtask

    task automatic strobe_sf();
        new_subframe = 1'b1;
        tick();
        new_subframe = 1'b0;
    endtask

    task automatic start_frame(input int id);
        plan_frame(id);
        N_cell_ID = 9'(id);
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        N_cell_ID = 9'($urandom_range(511, 0));
    endtask

    // Walks symbols 0..k_last of a frame already started.
    task automatic frame_body(input int id, input int k_last, input bit ovr_test);
        int  c;
        int  extra;
        int  lat_req = 1576;
        bit  armed = 1'b0;
        for (int k = 0; k <= k_last; k++) begin
            extra = 0;
            if (ovr_test && k == 3) begin
                repeat (20) tick();
                check("warm_before_strobe", int'(shift_en), 1);
                strobe_sf();
                repeat (3) tick();
                strobe_sf();
                extra = 25;
                armed = 1'b1;
                exp_ov++;
            end
            wait_ready(c);
            if (lat_req > 0) check("ready_latency", c + extra, lat_req);
            if (id == 1 && k == 4) check("cinit_id1_ns2", int'(cinit), 82947);
            if (id == 504 && k == 35) check("cinit_max", int'(cinit), 151883761);
            ack($urandom_range(3, 0));
            if (k == 35) begin
                tick();
                check("frame_done_pulse", int'(frame_done), 1);
                check("frame_all_consumed", exp_q.size(), 0);
                tick();
                check("frame_done_single", int'(frame_done), 0);
                exp_fd++;
            end else if (plan_sf[k+1] != plan_sf[k]) begin
                if (armed) begin
                    lat_req = 1578;
                    armed = 1'b0;
                end else begin
                    for (int n = 0; n < plan_sf[k+1] - plan_sf[k]; n++) begin
                        repeat (5) tick();
                        strobe_sf();
                    end
                    lat_req = 1576;
                end
            end else begin
                lat_req = 1577;
            end
        end
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int id_d;
        rst = 1'b1; new_frame = 1'b0; new_subframe = 1'b0; est_ack = 1'b0;
        N_cell_ID = 9'd0;
        repeat (3) tick();
        check("rst_ready", int'(NRS_gen_ready), 0);
        check("rst_seed", int'(seed_load), 0);
        check("rst_shift", int'(shift_en), 0);
        check("rst_ns", int'(ns), 0);
        check("rst_l", int'(l), 5);
        check("rst_cinit", int'(cinit), 0);
        check("rst_done", int'(frame_done), 0);
        rst = 1'b0;
        strobe_sf();
        repeat (3) tick();
        check("idle_ignores_sf", int'(seed_load | shift_en | NRS_gen_ready), 0);

        // Frame A: N_cell_ID = 0, long hold, est_ack during WARM.
        start_frame(0);
        tick();
        check("seed_after_calc", int'(seed_load), 1);
        check("cinit_id0", int'(cinit), 13313);
        tick();
        check("seed_one_cycle", int'(seed_load), 0);
        wait_ready(c);
        check("first_latency", c + 2, 1576);
        ack(100);
        repeat (10) tick();
        check("warm_for_stray_ack", int'(shift_en), 1);
        est_ack = 1'b1;
        tick();
        est_ack = 1'b0;
        wait_ready(c);
        check("latency_stray_ack", c + 11, 1577);
        ack(2);

        // Frame B: N_cell_ID = 1, pending and overrun, abort during ns=4 WARM.
        start_frame(1);
        frame_body(1, 7, 1'b1);
        repeat (30) tick();
        check("abort_warm", int'(shift_en), 1);
        check("abort_ns_before", int'(ns), 4);
        check("abort_l_before", int'(l), 5);
        start_frame(504);
        check("abort_shift_drop", int'(shift_en), 0);
        check("abort_ns", int'(ns), 0);
        check("abort_l", int'(l), 5);

        // Frame C: full frame with N_cell_ID = 504.
        frame_body(504, 35, 1'b0);
        check("idle_after_frame", int'(seed_load | shift_en | NRS_gen_ready), 0);

        // Frame D: random cell, reset while ready.
        id_d = $urandom_range(503, 0);
        start_frame(id_d);
        frame_body(id_d, 0, 1'b0);
        wait_ready(c);
        check("second_sym_latency", c, 1577);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("rst_ready_drop", int'(NRS_gen_ready), 0);
        check("rst_ns_mid", int'(ns), 0);
        check("rst_l_mid", int'(l), 5);
        check("rst_cinit_mid", int'(cinit), 0);
        repeat (10) tick();
        check("rst_stays_idle", int'(seed_load | shift_en | NRS_gen_ready), 0);

        check("frame_done_count", fd_cnt, exp_fd);
        check("overrun_count", ov_cnt, exp_ov);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nrs_symbol_scheduler.md
Name: nrs_symbol_scheduler

Overview:
- Controls the NRS Gold-sequence generator in the RX chain.
- Per frame, walks every NRS-bearing symbol (l=5,6 of each slot, skipping subframe 5, slots 10/11) in order.
- For each symbol: computes c_init, loads the seed, runs the warm-up and output shifts, raises NRS_gen_ready, and waits for est_ack from the channel estimator before moving on.

Parameters:
- WIDTH_B, 9, N_cell_ID width.
- NUM_SHIFTS, 1570, Gold warm-up shifts (1600-31+1).
- OUT_SHIFTS, 4, extra shifts that expose the 4 c(n) bits per symbol.
- CINIT_W, 28, c_init width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- new_frame  in  1  frame strobe; restarts the schedule and latches N_cell_ID.
- new_subframe  in  1  subframe strobe.
- N_cell_ID  in  WIDTH_B  cell ID, sampled only when new_frame=1.
- est_ack  in  1  estimator has consumed the current symbol.
- cinit  out  CINIT_W  registered seed for the generator x2.
- seed_load  out  1  generator loads x1=1, x2=cinit.
- shift_en  out  1  generator advances one step.
- ns  out  5  current slot number.
- l  out  3  current symbol index.
- NRS_gen_ready  out  1  generator output is valid for the estimator.
- frame_done  out  1  one-cycle pulse after the last symbol of subframe 9 is acked.
- sf_overrun  out  1  one-cycle pulse on a lost new_subframe.

Behaviour:
- Reset (edge with rst=1): state IDLE. All outputs 0, ns=0, l=5, internal sf=0, pending flag 0.
- Outputs are Moore-decoded from registered state:
  - seed_load=1 only in SEED.
  - shift_en=1 only in WARM.
  - NRS_gen_ready=1 only in READY.
- States:
  - IDLE: waits for new_frame.
  - CALC: one cycle; registers cinit = (7*(ns+1)+l+1)*(2*N_cell_ID+1)*1024 + 2*N_cell_ID+1. Unsigned; maximum value 151883761 fits 28 bits without truncation.
  - SEED: one cycle, then WARM.
  - WARM: exactly NUM_SHIFTS+OUT_SHIFTS cycles (11-bit down counter), then READY.
  - READY: holds until est_ack=1, then NEXT.
  - NEXT: one cycle; advances the symbol position:
    - If l=5: set l=6, go to CALC.
    - Else if ns is even: ns+1, l=5, go to CALC.
    - Else if sf=9: pulse frame_done, go to IDLE.
    - Else: go to WAIT_SF.
  - WAIT_SF: on new_subframe (or a pending flag), set sf+1.
    - If the new sf=5: stay in WAIT_SF (no NRS in subframe 5).
    - Else: ns=2*sf, l=5, go to CALC.
- Latency: new_frame sampled at edge E0 gives CALC after E0, SEED after E1, WARM for 1574 cycles starting after E2, NRS_gen_ready=1 after E2+1574. The next symbol in the same subframe has NRS_gen_ready after ack edge + 1577 cycles (NEXT, CALC, SEED, WARM).
- new_frame priority: new_frame in any state except under reset aborts the current schedule.
  - Latches N_cell_ID, sets ns=0, l=5, sf=0, clears pending, goes to CALC.
  - NRS_gen_ready drops the next cycle.
  - rst wins over new_frame.
- new_subframe handling:
  - Outside WAIT_SF and IDLE: sets pending.
  - Arriving while pending already set: pulse sf_overrun; pending stays 1.
  - In IDLE: ignored.
- Signals ignored outside their states:
  - est_ack outside READY is ignored.
  - est_ack and new_frame on the same edge: new_frame wins; no frame_done.
- ns and l hold their values in READY so the estimator can use them as a tag.
- ns never takes 10 or 11.
- Reset mid-WARM stops shift_en on the next cycle.

Test Plan:
- N_cell_ID=0, new_frame → cinit=13313 one cycle after new_frame is sampled; seed_load is a 1-cycle pulse; shift_en high for exactly 1574 cycles; NRS_gen_ready rises on the next cycle.
- N_cell_ID=1, ack symbols until ns=2, l=5 → cinit=82947. N_cell_ID=504, ns=19, l=6 → cinit=151883761.
- Full frame, new_subframe issued 5 cycles after each WAIT_SF entry → 36 READY periods with (ns,l) order 0/5, 0/6, 1/5, 1/6 … 9/6, 12/5 … 19/6. No ns=10 or 11. frame_done pulses once after the final ack.
- Hold est_ack low for 100 cycles in READY → NRS_gen_ready stays 1 and all outputs stable. est_ack pulse in WARM → no effect.
- new_subframe during WARM → pending; WAIT_SF is left after 1 cycle without another strobe. Two strobes during WARM → sf_overrun pulses once.
- new_frame during WARM of ns=4 → shift_en drops next cycle, ns=0, l=5, cinit recomputed with the new N_cell_ID. rst during READY → NRS_gen_ready=0 after that edge, state IDLE.
